spgd_metric_avg: RTL and testbench
==================================

// Module: spgd_metric_avg
// PURPOSE
//  Upstream stage of the metric path: measures the SPGD cost metric after each mirror update.
//  On a start pulse from the SPGD controller it waits a settle time, then averages 2^LOG2_N ADC
//  samples (12-bit unsigned) and outputs one 12-bit averaged metric with a valid strobe.
//  metric_out feeds the 12->48-bit fixed-point padder ahead of the 48-bit gradient arithmetic.
// PARAMETERS
//  IN_WIDTH      12  sample and metric width (unsigned)
//  LOG2_N        4   log2 of samples averaged per measurement (N=16)
//  SETTLE_CYCLES 8   clock cycles ignored after start (actuator settling); 0 = no settle
//  SETTLE_WIDTH  8   settle counter width; must hold SETTLE_CYCLES
// PORTS
//  clk           in   1         system clock, rising edge
//  rst           in   1         asynchronous reset, active high
//  start         in   1         single-cycle request to begin a measurement
//  sample_in     in   IN_WIDTH  ADC sample, unsigned
//  sample_valid  in   1         sample_in valid this cycle
//  metric_out    out  IN_WIDTH  averaged metric, held until next result
//  metric_valid  out  1         1-cycle strobe: metric_out updated
//  busy          out  1         high in SETTLE and ACCUM
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, acc=0, counters=0, metric_out=0,
//   metric_valid=0, busy=0. Reset mid-measurement aborts it; no metric_valid is produced.
//  States: IDLE, SETTLE, ACCUM.
//  IDLE:   start=1 -> SETTLE (settle counter cleared) or ACCUM directly if SETTLE_CYCLES=0;
//          acc and sample counter cleared on that edge.
//  SETTLE: exactly SETTLE_CYCLES cycles; sample_valid ignored; then -> ACCUM.
//  ACCUM:  each cycle with sample_valid=1 adds sample_in to acc (width IN_WIDTH+LOG2_N,
//          overflow impossible) and increments the sample count; cycles with
//          sample_valid=0 change nothing (gaps allowed, no timeout).
//          On the edge accepting the Nth sample: metric_out <= (acc+sample_in)>>LOG2_N
//          (truncation, no rounding), metric_valid <= 1, state -> IDLE.
//  metric_valid high for exactly one cycle, in IDLE after the measurement.
//  start is ignored while busy=1 (no queuing, no restart). A start in the
//   metric_valid cycle is accepted (state is IDLE) and begins a new measurement.
//  busy = (state != IDLE), registered with state.
//  Latency, continuous valid: start sampled at edge 0 -> busy cycles 1..S+N ->
//   metric_valid in cycle S+N+1 (S=8,N=16: cycle 25).
//  sample_in is don't-care when sample_valid=0; no X propagates into acc.
// TESTING
//  1 start, S=8, 16 consecutive samples 0xFFF -> metric_out=0xFFF, metric_valid only in cycle 25.
//  2 start, samples 0..15 continuous -> sum 120, metric_out=0x007 (truncated).
//  3 sample_in=0xFFF valid throughout SETTLE, then 16x 0x100 -> metric_out=0x100 (settle
//    samples discarded).
//  4 valid toggling every other cycle, 16x 0x0A5 -> metric_out=0x0A5 after 32 ACCUM cycles;
//    extra start pulses while busy -> still exactly one metric_valid.
//  5 rst asserted after 7 samples in ACCUM -> all outputs 0 same cycle; after release a new
//    start with 16x 0x321 -> metric_out=0x321 (no residue from aborted run).
//  6 start in the metric_valid cycle -> busy next cycle, second result after another S+N cycles.

Source files
------------

// File: rtl/spgd_metric_avg.sv
// spgd_metric_avg: SPGD cost-metric averager.
// After a start pulse, waits SETTLE_CYCLES for actuator settling, then
// accumulates 2^LOG2_N valid ADC samples and emits their truncated mean.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous reset, active high
//   start        - single-cycle measurement request (ignored while busy)
//   sample_in    - unsigned ADC sample
//   sample_valid - sample_in qualifier
//   metric_out   - averaged metric, held until the next result
//   metric_valid - one-cycle strobe marking a new metric_out
//   busy         - high while settling or accumulating
module spgd_metric_avg #(
    parameter int unsigned IN_WIDTH      = 12,
    parameter int unsigned LOG2_N        = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned SETTLE_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] sample_in,
    input  logic                sample_valid,
    output logic [IN_WIDTH-1:0] metric_out,
    output logic                metric_valid,
    output logic                busy
);

    localparam int unsigned ACC_W = IN_WIDTH + LOG2_N;
    localparam logic [SETTLE_WIDTH-1:0] SETTLE_LAST =
        SETTLE_WIDTH'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SETTLE_WIDTH-1:0] settle_q, settle_d;
    logic [LOG2_N-1:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [IN_WIDTH-1:0]     metric_q, metric_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic [ACC_W-1:0]        sum_c;

    // Next-state and datapath logic.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        metric_d = metric_q;
        valid_d  = 1'b0;
        // Only consumed when sample_valid is high, so an X on sample_in never reaches acc.
        sum_c    = acc_q + ACC_W'(sample_in);

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES == 0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ACCUM;
                end else begin
                    settle_d = settle_q + SETTLE_WIDTH'(1);
                end
            end
            ACCUM: begin
                if (sample_valid) begin
                    acc_d = sum_c;
                    cnt_d = cnt_q + LOG2_N'(1);
                    // Nth sample: divide by shifting, truncating the fraction.
                    if (cnt_q == CNT_LAST) begin
                        metric_d = sum_c[ACC_W-1:LOG2_N];
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            settle_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            metric_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            metric_q <= metric_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign metric_out   = metric_q;
    assign metric_valid = valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spgd_metric_avg.sv
// Directed self-checking bench for spgd_metric_avg (S=8, N=16).
// Cycle c is the clock period following edge c; the start pulse is sampled at edge 0.
module tb_spgd_metric_avg;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [11:0] metric_out;
    logic        metric_valid;
    logic        busy;

    int n_checks;
    int n_fail;

    spgd_metric_avg #(
        .IN_WIDTH     (12),
        .LOG2_N       (4),
        .SETTLE_CYCLES(8),
        .SETTLE_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .metric_out  (metric_out),
        .metric_valid(metric_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [11:0] d);
        start        = s;
        sample_valid = v;
        sample_in    = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 12'h000);
        tick();
        tick();
        n_checks++;
        if ({metric_out, metric_valid, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h valid=%b busy=%b, want 000/0/0",
                     metric_out, metric_valid, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    // Test 1: full-scale samples, strict latency and strobe width.
    task automatic test_full_scale();
        drive(1'b1, 1'b0, 12'h000);
        tick();
        for (int c = 1; c <= 30; c++) begin
            drive(1'b0, (c >= 9 && c <= 24), 12'hFFF);
            n_checks++;
            if (metric_valid !== (c == 25) || busy !== (c <= 24)) begin
                n_fail++;
                $display("FAIL full_scale_timing c=%0d: got valid=%b busy=%b, want %b/%b",
                         c, metric_valid, busy, (c == 25), (c <= 24));
            end
            if (c == 25) begin
                n_checks++;
                if (metric_out !== 12'hFFF) begin
                    n_fail++;
                    $display("FAIL full_scale_value: got %h, want fff", metric_out);
                end
            end
            tick();
        end
    endtask

    // Test 2: ramp 0..15, sum 120 truncates to 7.
    task automatic test_ramp();
        drive(1'b1, 1'b0, 12'h000);
        tick();
        for (int c = 1; c <= 27; c++) begin
            drive(1'b0, (c >= 9 && c <= 24), 12'(c - 9));
            if (c == 25) begin
                n_checks++;
                if (metric_valid !== 1'b1 || metric_out !== 12'h007) begin
                    n_fail++;
                    $display("FAIL ramp_trunc: got valid=%b out=%h, want 1/007",
                             metric_valid, metric_out);
                end
            end
            tick();
        end
    endtask

    // Test 3: valid samples during SETTLE are discarded.
    task automatic test_settle_discard();
        drive(1'b1, 1'b1, 12'hFFF);
        tick();
        for (int c = 1; c <= 27; c++) begin
            drive(1'b0, (c <= 24), (c <= 8) ? 12'hFFF : 12'h100);
            if (c == 25) begin
                n_checks++;
                if (metric_valid !== 1'b1 || metric_out !== 12'h100) begin
                    n_fail++;
                    $display("FAIL settle_discard: got valid=%b out=%h, want 1/100",
                             metric_valid, metric_out);
                end
            end
            tick();
        end
    endtask

    // Test 4: valid every other cycle plus spurious starts while busy.
    task automatic test_gaps();
        int strobes;
        strobes = 0;
        drive(1'b1, 1'b0, 12'h000);
        tick();
        for (int c = 1; c <= 50; c++) begin
            drive((c == 5 || c == 15 || c == 30),
                  (c >= 10 && c <= 40 && (c % 2 == 0)),
                  (c % 2 == 0) ? 12'h0A5 : 12'hF5A);
            if (metric_valid === 1'b1) strobes++;
            n_checks++;
            if (metric_valid !== (c == 41) || busy !== (c <= 40)) begin
                n_fail++;
                $display("FAIL gaps_timing c=%0d: got valid=%b busy=%b, want %b/%b",
                         c, metric_valid, busy, (c == 41), (c <= 40));
            end
            if (c == 41) begin
                n_checks++;
                if (metric_out !== 12'h0A5) begin
                    n_fail++;
                    $display("FAIL gaps_value: got %h, want 0a5", metric_out);
                end
            end
            tick();
        end
        n_checks++;
        if (strobes != 1) begin
            n_fail++;
            $display("FAIL gaps_strobe_count: got %0d, want 1", strobes);
        end
    endtask

    // Test 5: reset mid-ACCUM aborts cleanly, next run has no residue.
    task automatic test_reset_abort();
        drive(1'b1, 1'b0, 12'h000);
        tick();
        for (int c = 1; c <= 15; c++) begin
            drive(1'b0, (c >= 9), 12'h555);
            tick();
        end
        drive(1'b0, 1'b0, 12'h000);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({metric_out, metric_valid, busy} !== 14'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got out=%h valid=%b busy=%b, want 000/0/0",
                     metric_out, metric_valid, busy);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (metric_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle: got valid=%b busy=%b, want 0/0", metric_valid, busy);
            end
            tick();
        end
        drive(1'b1, 1'b0, 12'h000);
        tick();
        for (int c = 1; c <= 27; c++) begin
            drive(1'b0, (c >= 9 && c <= 24), 12'h321);
            if (c == 25) begin
                n_checks++;
                if (metric_valid !== 1'b1 || metric_out !== 12'h321) begin
                    n_fail++;
                    $display("FAIL abort_rerun: got valid=%b out=%h, want 1/321",
                             metric_valid, metric_out);
                end
            end
            tick();
        end
    endtask

    // Test 6: start in the metric_valid cycle launches the next measurement.
    task automatic test_back_to_back();
        logic exp_v;
        logic exp_b;
        drive(1'b1, 1'b0, 12'h000);
        tick();
        for (int c = 1; c <= 55; c++) begin
            drive((c == 25),
                  (c >= 9 && c <= 24) || (c >= 34 && c <= 49),
                  (c <= 25) ? 12'h010 : 12'h020);
            exp_v = (c == 25) || (c == 50);
            exp_b = (c <= 24) || (c >= 26 && c <= 49);
            n_checks++;
            if (metric_valid !== exp_v || busy !== exp_b) begin
                n_fail++;
                $display("FAIL b2b_timing c=%0d: got valid=%b busy=%b, want %b/%b",
                         c, metric_valid, busy, exp_v, exp_b);
            end
            if (c == 25 || c == 50) begin
                n_checks++;
                if (metric_out !== ((c == 25) ? 12'h010 : 12'h020)) begin
                    n_fail++;
                    $display("FAIL b2b_value c=%0d: got %h, want %h",
                             c, metric_out, (c == 25) ? 12'h010 : 12'h020);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_full_scale();
        test_ramp();
        test_settle_discard();
        test_gaps();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
